// File: rtl/key_pkg.sv
// Shared types and default constants for the multi-channel key debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } chan_state_e;

  localparam int CLK_HZ         = 200_000_000;
  localparam int DEF_SCAN_DIV   = 4_000_000;
  localparam int DEF_LONG_TICKS = 50;

endpackage

// File: rtl/key_chan.sv
// One key channel: synchronizer, tick sampler, two-sample debounce, press FSM and LED driver.
module key_chan
  import key_pkg::*;
#(
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int ACTIVE_LOW = 1
) (
  input  logic sys_clk_ibufg,
  input  logic rst_n,
  input  logic tick,
  input  logic key_raw,
  input  logic mode,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic led_out
);

  localparam int CW = $clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LONG_TICKS);

  logic          sync1, sync2, level, sample;
  logic          rise, fall;
  chan_state_e   state, state_nx;
  logic [CW-1:0] hold_cnt, hold_cnt_nx;
  logic          key_state_nx, press_nx, release_nx, long_nx, led_nx;

  assign level = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // A change is accepted only when two consecutive tick samples agree.
  assign rise = tick && (level == sample) && level && !key_state;
  assign fall = tick && (level == sample) && !level && key_state;

  always_ff @(posedge sys_clk_ibufg or negedge rst_n) begin
    if (!rst_n) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      sample        <= 1'b0;
      state         <= IDLE;
      hold_cnt      <= '0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      led_out       <= 1'b1;
    end else begin
      sync1         <= key_raw;
      sync2         <= sync1;
      if (tick) sample <= level;
      state         <= state_nx;
      hold_cnt      <= hold_cnt_nx;
      key_state     <= key_state_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      long_pulse    <= long_nx;
      led_out       <= led_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    hold_cnt_nx  = hold_cnt;
    key_state_nx = key_state;
    press_nx     = 1'b0;
    release_nx   = 1'b0;
    long_nx      = 1'b0;
    if (rise) key_state_nx = 1'b1;
    if (fall) key_state_nx = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx    = PRESS;
          hold_cnt_nx = '0;
          press_nx    = 1'b1;
        end
      end
      PRESS: begin
        if (fall) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
        end else if (tick) begin
          if (hold_cnt != CNT_MAX) hold_cnt_nx = hold_cnt + 1'b1;
          if (hold_cnt == CNT_LAST) begin
            state_nx = HELD;
            long_nx  = 1'b1;
          end
        end
      end
      HELD: begin
        if (fall) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Long press restores the LED to off even if a toggle lands in the same cycle.
    if (mode)             led_nx = ~key_state;
    else if (long_pulse)  led_nx = 1'b1;
    else if (press_pulse) led_nx = ~led_out;
    else                  led_nx = led_out;
  end

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel key debouncer with a shared scan prescaler and per-key press/release/long events.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              sys_clk_ibufg,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] led_mode,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] led_out
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge sys_clk_ibufg or negedge rst_n) begin
    if (!rst_n) pre_cnt <= '0;
    else        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_chan #(
      .LONG_TICKS (LONG_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .sys_clk_ibufg (sys_clk_ibufg),
      .rst_n         (rst_n),
      .tick          (tick),
      .key_raw       (key_in[i]),
      .mode          (led_mode[i]),
      .key_state     (key_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .led_out       (led_out[i])
    );
  end

endmodule
